// File: rtl/ib_mul_pkg.sv
// Shared constants and helpers for the 8x8 unsigned multiplier family.
package ib_mul_pkg;

  localparam int MUL_P_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Ceiling log2; elaboration-time use only (parameter checks and widths).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ib_skid_out.sv
// One-deep registered output stage for group sums.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   OUT_EMPTY | no sum held, o_valid low; a load moves to OUT_FULL
//   OUT_FULL  | sum held, o_valid high; drain without load empties it,
//             | drain with load keeps it full with the new sum
//
// The upstream gating of o_ready guarantees a load never arrives while
// full unless the held sum is draining in the same cycle.
module ib_skid_out
  import ib_mul_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_sum
);

  out_state_e state, state_nxt;

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= OUT_EMPTY;
    else         state <= state_nxt;
  end

  // Next-state: load fills, drain without load empties.
  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (i_load) state_nxt = OUT_FULL;
      OUT_FULL:  if (i_ready && !i_load) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  // Sum register only changes on load; it keeps its value after drain.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)     o_sum <= '0;
    else if (i_load) o_sum <= i_data;
  end

  assign o_valid = (state == OUT_FULL);

endmodule

// File: rtl/ib_mul_acc.sv
// Accumulates groups of N_ACC 16-bit products and presents each group sum
// through a registered valid/ready output.
module ib_mul_acc
  import ib_mul_pkg::*;
#(
  parameter int N_ACC = 4,
  parameter int ACC_W = 18
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic                      i_clr,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [MUL_P_W-1:0]        i_p,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [ACC_W-1:0]          o_sum,
  output logic [clog2(N_ACC)-1:0]   o_cnt
);

  localparam int CNT_W = clog2(N_ACC);

  if (N_ACC < 2) begin : g_nacc_chk
    $error("ib_mul_acc: N_ACC must be at least 2");
  end
  if (ACC_W < MUL_P_W + clog2(N_ACC)) begin : g_accw_chk
    $error("ib_mul_acc: ACC_W too narrow to hold a full group sum");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             acc_fire;
  logic             last_fire;

  assign last      = (cnt == CNT_W'(N_ACC - 1));
  // Only the final beat of a group is held off by a stalled output, so the
  // next group can prefill while the consumer is busy.
  assign o_ready   = ~i_clr & ~(last & o_valid & ~i_ready);
  assign acc_fire  = i_valid & o_ready;
  assign last_fire = acc_fire & last;
  assign acc_sum   = acc + ACC_W'(i_p);
  assign o_cnt     = cnt;

  // Partial-group accumulator and beat counter; clear wins over accept.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      acc <= '0;
      cnt <= '0;
    end else if (i_clr || last_fire) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_fire) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

  ib_skid_out #(
    .W(ACC_W)
  ) u_out (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_load  (last_fire),
    .i_data  (acc_sum),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_sum   (o_sum)
  );

endmodule

// File: tb/tb_ib_mul_acc.sv
module tb_ib_mul_acc;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_p = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [17:0] o_sum;
  logic [1:0]  o_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  logic [17:0] exp_q[$];

  ib_mul_acc #(.N_ACC(4), .ACC_W(18)) dut (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_p     (i_p),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cnt   (o_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every sum the consumer takes must match the head of the queue.
  always @(negedge i_clk) begin
    if (i_nrst && o_valid && i_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sum_unexpected: got %0h with no expected sum queued", o_sum);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if (o_sum !== e) begin
          n_bad++;
          $display("FAIL sum: got %0h expected %0h at %0t", o_sum, e, $time);
        end
      end
    end
  end

  // Offer one beat, wait (bounded) until accepted; returns at posedge+1.
  task automatic beat(input logic [15:0] p);
    bit done;
    done = 0;
    i_valid = 1'b1;
    i_p = p;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge i_clk);
      if (o_ready) done = 1;
      else stalls++;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_p = 16'hDEAD;
    if (!done) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    i_nrst = 1'b1;
    idle(2);
    chk("rst_ready", 32'(o_ready), 32'd1);

    // Basic group 1,2,3,4 -> 10, one cycle latency then low
    exp_q.push_back(18'd10);
    stalls = 0;
    beat(16'd1); beat(16'd2); beat(16'd3); beat(16'd4);
    chk("g1_stalls", 32'(stalls), 32'd0);
    chk("g1_valid", 32'(o_valid), 32'd1);
    chk("g1_sum", 32'(o_sum), 32'd10);
    idle(1);
    chk("g1_valid_low", 32'(o_valid), 32'd0);
    chk("g1_sum_hold", 32'(o_sum), 32'd10);

    // Max products, no wrap; then two back-to-back groups
    exp_q.push_back(18'h3FFFC);
    for (int k = 0; k < 4; k++) beat(16'hFFFF);
    idle(2);
    exp_q.push_back(18'h3FFFC);
    exp_q.push_back(18'h3FFFC);
    stalls = 0;
    for (int k = 0; k < 8; k++) beat(16'hFFFF);
    chk("b2b_stalls", 32'(stalls), 32'd0);
    idle(2);

    // Backpressure: group done with consumer stalled, next group prefills
    i_ready = 1'b0;
    exp_q.push_back(18'd10);
    beat(16'd1); beat(16'd2); beat(16'd3); beat(16'd4);
    beat(16'd5); beat(16'd6); beat(16'd7);
    chk("bp_cnt", 32'(o_cnt), 32'd3);
    i_valid = 1'b1;
    i_p = 16'd8;
    @(negedge i_clk);
    chk("bp_ready_low", 32'(o_ready), 32'd0);
    chk("bp_sum_hold", 32'(o_sum), 32'd10);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("bp_ready_low2", 32'(o_ready), 32'd0);
    chk("bp_valid_hold", 32'(o_valid), 32'd1);
    @(posedge i_clk); #1;
    exp_q.push_back(18'd26);
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_ready_up", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("bp_new_valid", 32'(o_valid), 32'd1);
    chk("bp_new_sum", 32'(o_sum), 32'd26);
    idle(2);

    // Clear after two products, with a beat offered in the clear cycle
    beat(16'd7); beat(16'd9);
    chk("clr_pre_cnt", 32'(o_cnt), 32'd2);
    i_clr = 1'b1;
    i_valid = 1'b1;
    i_p = 16'd100;
    @(negedge i_clk);
    chk("clr_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    i_clr = 1'b0;
    i_valid = 1'b0;
    chk("clr_cnt", 32'(o_cnt), 32'd0);
    exp_q.push_back(18'd4);
    for (int k = 0; k < 4; k++) beat(16'd1);
    idle(2);

    // Async reset mid-group while a sum is held
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(16'd1);
    beat(16'd2); beat(16'd2);
    chk("prerst_valid", 32'(o_valid), 32'd1);
    #3;
    i_nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_sum", 32'(o_sum), 32'd0);
    chk("arst_cnt", 32'(o_cnt), 32'd0);
    idle(2);
    i_nrst = 1'b1;
    i_ready = 1'b1;
    idle(1);
    exp_q.push_back(18'd8);
    for (int k = 0; k < 4; k++) beat(16'd2);
    idle(2);

    // Gapped valid: idle cycles carry junk products that must be ignored
    exp_q.push_back(18'd24);
    beat(16'd3);
    i_p = 16'h1234; idle(1);
    beat(16'd5);
    i_p = 16'hFFFF; idle(1);
    beat(16'd7);
    i_p = 16'h0F0F; idle(1);
    chk("gap_cnt", 32'(o_cnt), 32'd3);
    beat(16'd9);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
